// File: rtl/control_fsm_if.sv
// rtl/control_fsm_if.sv - datapath flag/opcode inputs and control strobes of control_fsm
//
// Purpose: bundles the signals between the multi-cycle controller and its datapath.
// Ports:
//   i_N, i_Z        registered negative / zero flags from the datapath
//   i_instr[3:0]    opcode field IR[3:0]
//   i_imm           immediate-form select IR[4]
//   o_*             datapath control strobes and selects
//   o_state[2:0]    current controller state (debug)
//   o_instr_done    one-cycle pulse in the last cycle of each instruction
// Modports: master = controller side, slave = datapath side.

interface control_fsm_if;
   logic       i_N;
   logic       i_Z;
   logic [3:0] i_instr;
   logic       i_imm;

   logic       o_PC_write;
   logic       o_Addr_sel;
   logic       o_mem_rd;
   logic       o_mem_wr;
   logic       o_MDR_load;
   logic       o_IR_load;
   logic       o_OpA_sel;
   logic       o_OpAB_load;
   logic       o_ALU_out;
   logic       o_RF_write;
   logic       o_Reg_in;
   logic       o_Flag_write;
   logic       o_RF_write_call;
   logic       o_mov_hi;
   logic [1:0] o_ALU_1_sel;
   logic [1:0] o_ALU_2_sel;
   logic [1:0] o_ALUop_sel;
   logic [2:0] o_state;
   logic       o_instr_done;

   modport master (
      input  i_N, i_Z, i_instr, i_imm,
      output o_PC_write, o_Addr_sel, o_mem_rd, o_mem_wr, o_MDR_load, o_IR_load,
             o_OpA_sel, o_OpAB_load, o_ALU_out, o_RF_write, o_Reg_in, o_Flag_write,
             o_RF_write_call, o_mov_hi, o_ALU_1_sel, o_ALU_2_sel, o_ALUop_sel,
             o_state, o_instr_done
   );

   modport slave (
      output i_N, i_Z, i_instr, i_imm,
      input  o_PC_write, o_Addr_sel, o_mem_rd, o_mem_wr, o_MDR_load, o_IR_load,
             o_OpA_sel, o_OpAB_load, o_ALU_out, o_RF_write, o_Reg_in, o_Flag_write,
             o_RF_write_call, o_mov_hi, o_ALU_1_sel, o_ALU_2_sel, o_ALUop_sel,
             o_state, o_instr_done
   );
endinterface

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - multi-cycle processor control FSM
//
// Purpose: sequences fetch / decode / register read / execute / writeback for a
// small 16-bit processor and drives the datapath control strobes.
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous active-low reset
//   bus   control_fsm_if.master: flags and opcode in, control strobes out

module control_fsm (
   input  logic              clk,
   input  logic              rst,
   control_fsm_if.master     bus
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_RDREG   = 3'd2,
      S_EXEC    = 3'd3,
      S_LD_WAIT = 3'd4,
      S_WB      = 3'd5,
      S_CALL_WB = 3'd6,
      S_JUMP    = 3'd7
   } state_t;

   localparam logic [3:0] OP_MV   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_CMP  = 4'b0011;
   localparam logic [3:0] OP_LD   = 4'b0100;
   localparam logic [3:0] OP_ST   = 4'b0101;
   localparam logic [3:0] OP_MVHI = 4'b0110;
   localparam logic [3:0] OP_J    = 4'b1000;
   localparam logic [3:0] OP_JZ   = 4'b1001;
   localparam logic [3:0] OP_JN   = 4'b1010;
   localparam logic [3:0] OP_CALL = 4'b1100;

   state_t state;
   state_t state_nxt;

   // Flags are consulted only when the EXEC outputs are decoded, so a flag
   // written by the previous instruction's last cycle is already visible.
   logic jump_taken;
   assign jump_taken = (bus.i_instr == OP_J)
                     | ((bus.i_instr == OP_JZ) & bus.i_Z)
                     | ((bus.i_instr == OP_JN) & bus.i_N);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_FETCH;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = S_FETCH;
      case (state)
         S_FETCH:   state_nxt = S_DECODE;
         S_DECODE:  state_nxt = S_RDREG;
         S_RDREG:   state_nxt = S_EXEC;
         S_EXEC: begin
            case (bus.i_instr)
               OP_MV, OP_ADD, OP_SUB, OP_MVHI: state_nxt = S_WB;
               OP_LD:                          state_nxt = S_LD_WAIT;
               OP_CALL:                        state_nxt = S_CALL_WB;
               default:                        state_nxt = S_FETCH;
            endcase
         end
         S_LD_WAIT: state_nxt = S_WB;
         S_WB:      state_nxt = S_FETCH;
         S_CALL_WB: state_nxt = S_JUMP;
         S_JUMP:    state_nxt = S_FETCH;
         default:   state_nxt = S_FETCH;
      endcase
   end

   // Output decode (ungated)
   logic       pc_write, addr_sel, mem_rd, mem_wr, mdr_load, ir_load;
   logic       opab_load, alu_out, rf_write, reg_in, flag_write, rf_write_call, mov_hi;
   logic       instr_done;
   logic [1:0] alu_1_sel, alu_2_sel, aluop_sel;

   always_comb begin
      pc_write      = 1'b0;
      addr_sel      = 1'b0;
      mem_rd        = 1'b0;
      mem_wr        = 1'b0;
      mdr_load      = 1'b0;
      ir_load       = 1'b0;
      opab_load     = 1'b0;
      alu_out       = 1'b0;
      rf_write      = 1'b0;
      reg_in        = 1'b0;
      flag_write    = 1'b0;
      rf_write_call = 1'b0;
      mov_hi        = 1'b0;
      instr_done    = 1'b0;
      alu_1_sel     = 2'b00;
      alu_2_sel     = 2'b00;
      aluop_sel     = 2'b00;

      case (state)
         S_FETCH: begin
            // PC <- PC + 2 while the instruction word is read
            addr_sel  = 1'b1;
            mem_rd    = 1'b1;
            pc_write  = 1'b1;
            alu_1_sel = 2'b00;
            alu_2_sel = 2'b01;
            aluop_sel = 2'b00;
         end
         S_DECODE: ir_load   = 1'b1;
         S_RDREG:  opab_load = 1'b1;
         S_EXEC: begin
            case (bus.i_instr)
               OP_MV, OP_ADD, OP_SUB, OP_CMP: begin
                  // mv passes operand B through by adding it to zero
                  alu_1_sel  = (bus.i_instr == OP_MV) ? 2'b11 : 2'b01;
                  alu_2_sel  = bus.i_imm ? 2'b10 : 2'b00;
                  aluop_sel  = (bus.i_instr == OP_SUB || bus.i_instr == OP_CMP) ? 2'b01 : 2'b00;
                  alu_out    = (bus.i_instr != OP_CMP);
                  flag_write = (bus.i_instr != OP_MV);
                  instr_done = (bus.i_instr == OP_CMP);
               end
               OP_MVHI: begin
                  alu_out = 1'b1;
                  mov_hi  = 1'b1;
               end
               OP_LD: mem_rd = 1'b1;
               OP_ST: begin
                  mem_wr     = 1'b1;
                  instr_done = 1'b1;
               end
               OP_J, OP_JZ, OP_JN: begin
                  pc_write   = jump_taken;
                  alu_1_sel  = jump_taken ? (bus.i_imm ? 2'b00 : 2'b11) : 2'b00;
                  alu_2_sel  = jump_taken ? (bus.i_imm ? 2'b11 : 2'b00) : 2'b00;
                  instr_done = 1'b1;
               end
               OP_CALL: begin
                  // return address (already-incremented PC) passes through the ALU
                  alu_1_sel = 2'b00;
                  aluop_sel = 2'b10;
                  alu_out   = 1'b1;
               end
               default: instr_done = 1'b1;
            endcase
         end
         S_LD_WAIT: mdr_load = 1'b1;
         S_WB: begin
            rf_write   = 1'b1;
            reg_in     = (bus.i_instr == OP_LD);
            instr_done = 1'b1;
         end
         S_CALL_WB: begin
            rf_write      = 1'b1;
            rf_write_call = 1'b1;
         end
         S_JUMP: begin
            pc_write   = 1'b1;
            alu_1_sel  = bus.i_imm ? 2'b00 : 2'b11;
            alu_2_sel  = bus.i_imm ? 2'b11 : 2'b00;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset forces every output low asynchronously, including the FETCH strobes
   // that the reset state would otherwise decode to.
   always_comb begin
      bus.o_PC_write      = rst & pc_write;
      bus.o_Addr_sel      = rst & addr_sel;
      bus.o_mem_rd        = rst & mem_rd;
      bus.o_mem_wr        = rst & mem_wr;
      bus.o_MDR_load      = rst & mdr_load;
      bus.o_IR_load       = rst & ir_load;
      bus.o_OpA_sel       = 1'b0;
      bus.o_OpAB_load     = rst & opab_load;
      bus.o_ALU_out       = rst & alu_out;
      bus.o_RF_write      = rst & rf_write;
      bus.o_Reg_in        = rst & reg_in;
      bus.o_Flag_write    = rst & flag_write;
      bus.o_RF_write_call = rst & rf_write_call;
      bus.o_mov_hi        = rst & mov_hi;
      bus.o_instr_done    = rst & instr_done;
      bus.o_ALU_1_sel     = rst ? alu_1_sel : 2'b00;
      bus.o_ALU_2_sel     = rst ? alu_2_sel : 2'b00;
      bus.o_ALUop_sel     = rst ? aluop_sel : 2'b00;
      bus.o_state         = rst ? state     : 3'd0;
   end

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - scoreboard testbench for control_fsm

module tb_control_fsm;

   logic clk = 1'b0;
   logic rst = 1'b0;

   control_fsm_if bus();

   control_fsm dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   // strobe masks, order PC_write .. mov_hi
   localparam logic [13:0] PCW  = 14'h2000;
   localparam logic [13:0] ASEL = 14'h1000;
   localparam logic [13:0] MRD  = 14'h0800;
   localparam logic [13:0] MWR  = 14'h0400;
   localparam logic [13:0] MDRL = 14'h0200;
   localparam logic [13:0] IRL  = 14'h0100;
   localparam logic [13:0] ABL  = 14'h0040;
   localparam logic [13:0] ALUO = 14'h0020;
   localparam logic [13:0] RFW  = 14'h0010;
   localparam logic [13:0] RIN  = 14'h0008;
   localparam logic [13:0] FW   = 14'h0004;
   localparam logic [13:0] RFWC = 14'h0002;
   localparam logic [13:0] MVHI = 14'h0001;
   localparam logic [13:0] NONE = 14'h0000;

   // {state, done, strobes[13:0], ALU_1, ALU_2, ALUop}
   logic [23:0] act;
   assign act = {bus.o_state, bus.o_instr_done,
                 bus.o_PC_write, bus.o_Addr_sel, bus.o_mem_rd, bus.o_mem_wr,
                 bus.o_MDR_load, bus.o_IR_load, bus.o_OpA_sel, bus.o_OpAB_load,
                 bus.o_ALU_out, bus.o_RF_write, bus.o_Reg_in, bus.o_Flag_write,
                 bus.o_RF_write_call, bus.o_mov_hi,
                 bus.o_ALU_1_sel, bus.o_ALU_2_sel, bus.o_ALUop_sel};

   function automatic logic [23:0] v(input logic [2:0] s, input logic d, input logic [13:0] sb,
                                     input logic [1:0] a1, input logic [1:0] a2, input logic [1:0] op);
      return {s, d, sb, a1, a2, op};
   endfunction

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [23:0] exp_q[$];
   string       name_q[$];

   task automatic check(input string nm, input logic [23:0] got, input logic [23:0] want);
      total_cnt++;
      if (got === want) pass_cnt++;
      else $display("FAIL %s: got %h required %h", nm, got, want);
   endtask

   task automatic expect_v(input string nm, input logic [23:0] e);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic expect_fdr(input string nm);
      expect_v({nm, ".fetch"},  v(3'd0, 1'b0, PCW | ASEL | MRD, 2'b00, 2'b01, 2'b00));
      expect_v({nm, ".decode"}, v(3'd1, 1'b0, IRL, 2'b00, 2'b00, 2'b00));
      expect_v({nm, ".rdreg"},  v(3'd2, 1'b0, ABL, 2'b00, 2'b00, 2'b00));
   endtask

   task automatic start(input logic [3:0] ins, input logic im, input logic n, input logic z);
      bus.i_instr = ins;
      bus.i_imm   = im;
      bus.i_N     = n;
      bus.i_Z     = z;
   endtask

   task automatic cycles(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Monitor: every cycle out of reset with a pending expectation is compared.
   logic [23:0] mon_e;
   string       mon_n;
   always @(negedge clk) begin
      if (rst && exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_n = name_q.pop_front();
         check(mon_n, act, mon_e);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   initial begin
      start(4'b0000, 1'b0, 1'b0, 1'b0);
      #1;
      check("reset_idle", act, 24'h0);
      @(posedge clk); #1;
      check("reset_after_edge", act, 24'h0);
      rst = 1'b1;

      // add reg
      start(4'b0001, 1'b0, 1'b0, 1'b0);
      expect_fdr("add");
      expect_v("add.exec", v(3'd3, 1'b0, ALUO | FW, 2'b01, 2'b00, 2'b00));
      expect_v("add.wb",   v(3'd5, 1'b1, RFW, 2'b00, 2'b00, 2'b00));
      cycles(5);

      // add imm
      start(4'b0001, 1'b1, 1'b0, 1'b0);
      expect_fdr("addi");
      expect_v("addi.exec", v(3'd3, 1'b0, ALUO | FW, 2'b01, 2'b10, 2'b00));
      expect_v("addi.wb",   v(3'd5, 1'b1, RFW, 2'b00, 2'b00, 2'b00));
      cycles(5);

      // sub reg
      start(4'b0010, 1'b0, 1'b0, 1'b0);
      expect_fdr("sub");
      expect_v("sub.exec", v(3'd3, 1'b0, ALUO | FW, 2'b01, 2'b00, 2'b01));
      expect_v("sub.wb",   v(3'd5, 1'b1, RFW, 2'b00, 2'b00, 2'b00));
      cycles(5);

      // mv imm
      start(4'b0000, 1'b1, 1'b0, 1'b0);
      expect_fdr("mvi");
      expect_v("mvi.exec", v(3'd3, 1'b0, ALUO, 2'b11, 2'b10, 2'b00));
      expect_v("mvi.wb",   v(3'd5, 1'b1, RFW, 2'b00, 2'b00, 2'b00));
      cycles(5);

      // mvhi
      start(4'b0110, 1'b1, 1'b0, 1'b0);
      expect_fdr("mvhi");
      expect_v("mvhi.exec", v(3'd3, 1'b0, ALUO | MVHI, 2'b00, 2'b00, 2'b00));
      expect_v("mvhi.wb",   v(3'd5, 1'b1, RFW, 2'b00, 2'b00, 2'b00));
      cycles(5);

      // cmp reg
      start(4'b0011, 1'b0, 1'b1, 1'b1);
      expect_fdr("cmp");
      expect_v("cmp.exec", v(3'd3, 1'b1, FW, 2'b01, 2'b00, 2'b01));
      cycles(4);

      // jz imm, Z=0: not taken
      start(4'b1001, 1'b1, 1'b0, 1'b0);
      expect_fdr("jz_nt");
      expect_v("jz_nt.exec", v(3'd3, 1'b1, NONE, 2'b00, 2'b00, 2'b00));
      cycles(4);

      // jz imm, Z=1: taken
      start(4'b1001, 1'b1, 1'b0, 1'b1);
      expect_fdr("jz_t");
      expect_v("jz_t.exec", v(3'd3, 1'b1, PCW, 2'b00, 2'b11, 2'b00));
      cycles(4);

      // jz imm, Z rises only just before EXEC: flag taken from EXEC cycle
      start(4'b1001, 1'b1, 1'b0, 1'b0);
      expect_fdr("jz_late");
      expect_v("jz_late.exec", v(3'd3, 1'b1, PCW, 2'b00, 2'b11, 2'b00));
      cycles(3);
      bus.i_Z = 1'b1;
      cycles(1);

      // jn reg, N=1: taken, register target
      start(4'b1010, 1'b0, 1'b1, 1'b0);
      expect_fdr("jn_t");
      expect_v("jn_t.exec", v(3'd3, 1'b1, PCW, 2'b11, 2'b00, 2'b00));
      cycles(4);

      // jn reg, N=0 Z=1: not taken
      start(4'b1010, 1'b0, 1'b0, 1'b1);
      expect_fdr("jn_nt");
      expect_v("jn_nt.exec", v(3'd3, 1'b1, NONE, 2'b00, 2'b00, 2'b00));
      cycles(4);

      // j imm
      start(4'b1000, 1'b1, 1'b0, 1'b0);
      expect_fdr("j");
      expect_v("j.exec", v(3'd3, 1'b1, PCW, 2'b00, 2'b11, 2'b00));
      cycles(4);

      // ld
      start(4'b0100, 1'b0, 1'b0, 1'b0);
      expect_fdr("ld");
      expect_v("ld.exec",  v(3'd3, 1'b0, MRD, 2'b00, 2'b00, 2'b00));
      expect_v("ld.wait",  v(3'd4, 1'b0, MDRL, 2'b00, 2'b00, 2'b00));
      expect_v("ld.wb",    v(3'd5, 1'b1, RFW | RIN, 2'b00, 2'b00, 2'b00));
      cycles(6);

      // st
      start(4'b0101, 1'b0, 1'b0, 1'b0);
      expect_fdr("st");
      expect_v("st.exec", v(3'd3, 1'b1, MWR, 2'b00, 2'b00, 2'b00));
      cycles(4);

      // call reg
      start(4'b1100, 1'b0, 1'b0, 1'b0);
      expect_fdr("call");
      expect_v("call.exec", v(3'd3, 1'b0, ALUO, 2'b00, 2'b00, 2'b10));
      expect_v("call.cwb",  v(3'd6, 1'b0, RFW | RFWC, 2'b00, 2'b00, 2'b00));
      expect_v("call.jump", v(3'd7, 1'b1, PCW, 2'b11, 2'b00, 2'b00));
      cycles(6);

      // call imm
      start(4'b1100, 1'b1, 1'b0, 1'b0);
      expect_fdr("calli");
      expect_v("calli.exec", v(3'd3, 1'b0, ALUO, 2'b00, 2'b00, 2'b10));
      expect_v("calli.cwb",  v(3'd6, 1'b0, RFW | RFWC, 2'b00, 2'b00, 2'b00));
      expect_v("calli.jump", v(3'd7, 1'b1, PCW, 2'b00, 2'b11, 2'b00));
      cycles(6);

      // undefined opcode
      start(4'b1111, 1'b1, 1'b1, 1'b1);
      expect_fdr("undef");
      expect_v("undef.exec", v(3'd3, 1'b1, NONE, 2'b00, 2'b00, 2'b00));
      cycles(4);

      // ld aborted by reset in LD_WAIT
      start(4'b0100, 1'b0, 1'b0, 1'b0);
      expect_fdr("ld_rst");
      expect_v("ld_rst.exec", v(3'd3, 1'b0, MRD, 2'b00, 2'b00, 2'b00));
      cycles(4);
      rst = 1'b0;
      #1;
      check("ld_rst.async_zero", act, 24'h0);
      cycles(1);
      check("ld_rst.held_zero", act, 24'h0);
      rst = 1'b1;

      // restart after reset: fresh fetch, no stale writeback
      start(4'b0001, 1'b0, 1'b0, 1'b0);
      expect_fdr("post_rst");
      expect_v("post_rst.exec", v(3'd3, 1'b0, ALUO | FW, 2'b01, 2'b00, 2'b00));
      expect_v("post_rst.wb",   v(3'd5, 1'b1, RFW, 2'b00, 2'b00, 2'b00));
      cycles(5);

      cycles(2);
      check("scoreboard_drained", 24'(exp_q.size()), 24'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
